dot_product_ctrl: RTL
=====================

// Module: dot_product_ctrl
// PURPOSE
//  Downstream consumer of the two operand RAMs (vector A, vector B) in the dotProduct datapath.
//  On start, sweeps addresses 0..len-1 over both RAM read ports in lock-step and multiply-accumulates
//  the returned words (unsigned). Presents the final sum on a valid/ready result port.
//  Holds the result until it is accepted, then returns to idle.
// PARAMETERS
//  ADDR_WIDTH  4   RAM address width; shared read address for A and B RAMs
//  DATA_WIDTH  8   RAM word width (unsigned operands)
//  VEC_LEN     16  max vector length; must be <= 2**ADDR_WIDTH
//  ACC_WIDTH   20  accumulator/result width; lossless when >= 2*DATA_WIDTH+clog2(VEC_LEN)
// PORTS
//  clk           in   1             single clock, rising edge
//  rst_n         in   1             asynchronous, active-low reset
//  start         in   1             pulse/level; sampled only in IDLE
//  len           in   ADDR_WIDTH+1  element count, captured with start
//  busy          out  1             high in FETCH, DRAIN and DONE
//  rd_en         out  1             read enable to both RAMs
//  rd_addr       out  ADDR_WIDTH    read address to both RAMs
//  a_data        in   DATA_WIDTH    A RAM data_out; valid 1 cycle after rd_en
//  b_data        in   DATA_WIDTH    B RAM data_out; valid 1 cycle after rd_en
//  result        out  ACC_WIDTH     dot product
//  result_valid  out  1             result held stable while high
//  result_ready  in   1             consumer accept
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, rd_en, result_valid = 0; rd_addr, result, acc = 0.
//  RAM read latency is exactly 1 cycle (registered data_out). A 1-bit pipe flag rd_vld tracks rd_en
//  delayed by 1 cycle. Accumulate on every edge where rd_vld=1: acc <= acc + a_data*b_data.
//  The full 2*DATA_WIDTH product is zero-extended to ACC_WIDTH. The sum wraps mod 2**ACC_WIDTH.
//  len is clamped: len > VEC_LEN -> VEC_LEN.
//  FSM:
//   IDLE : start=1 and len!=0 -> capture len, clear acc, goto FETCH.
//          start=1 and len==0 -> result=0, goto DONE. Otherwise remain.
//   FETCH: rd_en=1, rd_addr = 0,1,..,len-1 (one per cycle). After issuing addr len-1 -> DRAIN.
//   DRAIN: rd_en=0; the last product is accumulated at the end of this cycle; result<=final sum -> DONE.
//   DONE : result_valid=1; result/valid held until result_ready=1, then -> IDLE (valid drops next cycle).
//  Latency: with start sampled at edge 0, result_valid first goes high in the cycle after edge len+2.
//   This is len+2 cycles later; for len=0 it is 1 cycle later.
//  start while busy: ignored (no queueing). len is sampled only together with an accepted start.
//  result_ready while not DONE: ignored. result_ready tied high: valid is a 1-cycle pulse.
//   Back-to-back start is accepted in the IDLE cycle after the handshake.
//  rd_addr never exceeds len-1. rd_addr returns to 0 outside FETCH. rd_en is never high outside FETCH.
//  Reset mid-operation: immediate abort; all outputs return to reset values; partial acc is discarded.
// STRUCTURE
//  Shared package dotp_pkg holds:
//   - state encoding localparams (IDLE, FETCH, DRAIN, DONE)
//   - clog2 helper
//   - default widths, so the RAM, controller and bench agree
//  One natural sub-module, dotp_mac: a registered unsigned multiply-accumulate with clr/en inputs.
//   Its width parameters are DATA_WIDTH and ACC_WIDTH. The FSM, address counter and result
//   handshake stay in dot_product_ctrl.
// TESTING
//  Bench: two RAM models with 1-cycle registered read. A[i]=i+1, B[i]=2 unless stated. Check every cycle.
//  1 Basic: len=4 -> rd_addr 0,1,2,3 on 4 consecutive rd_en cycles; result=20 (2+4+6+8);
//    valid high exactly 6 cycles after the start edge.
//  2 Full/max: len=16, A=B=255 -> result=1040400 (0xFE010), no wrap.
//    len=20 clamps to 16 (same result, rd_addr max 15).
//  3 Zero length: len=0 -> no rd_en pulse; result=0, valid 1 cycle after start.
//  4 Backpressure: ready low 10 cycles -> result/valid stable throughout.
//    start pulses during DONE ignored; ready high -> IDLE; new start accepted next cycle.
//  5 Reset mid-FETCH: rst_n low at addr 2 of len=8 -> async clear of rd_en/busy/result.
//    Next run len=2 -> result=6 (no stale acc).
//  6 Wrap: ACC_WIDTH=16, len=2, A=B=255 -> result=(2*65025) mod 65536=64514.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared widths, state encoding and helpers for the dot-product datapath.
// RAM models, controller and bench all pull defaults from here.
package dotp_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int VEC_LEN_DEF    = 16;
  localparam int ACC_WIDTH_DEF  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dotp_mac.sv
// Registered unsigned multiply-accumulate.
// clr has priority over en; the sum wraps at ACC_WIDTH.
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] prod;

  assign prod = {{DATA_WIDTH{1'b0}}, a}
              * {{DATA_WIDTH{1'b0}}, b};

  // accumulator: clear on new job, add product when data is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Sweeps both operand RAMs in lock-step and returns the dot product
// on a valid/ready port; result held until accepted.
module dot_product_ctrl
  import dotp_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [ADDR_WIDTH:0] LenMax =
    (ADDR_WIDTH+1)'(VEC_LEN);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, len_clamp;
  logic [ACC_WIDTH-1:0]  res_q, res_d, acc;
  logic                  rd_vld_q;
  logic                  mac_clr;
  logic                  last;

  assign len_clamp = (len > LenMax) ? LenMax : len;
  assign last      = ({1'b0, addr_q} == len_q - 1'b1);
  assign rd_addr   = addr_q;
  assign result    = res_q;

  // next-state, counters and outputs
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    res_d        = res_q;
    mac_clr      = 1'b0;
    busy         = 1'b1;
    rd_en        = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (len_clamp != '0) begin
            len_d   = len_clamp;
            mac_clr = 1'b1;
            state_d = FETCH;
          end else begin
            res_d   = '0;
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        rd_en = 1'b1;
        if (last) begin
          addr_d  = '0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // wait until the final product has landed in acc
        if (!rd_vld_q) begin
          res_d   = acc;
          state_d = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      res_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      res_q    <= res_d;
      rd_vld_q <= rd_en;
    end
  end

  dotp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (rd_vld_q),
    .a     (a_data),
    .b     (b_data),
    .acc   (acc)
  );

endmodule
